id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that sits directly upstream of the execute ALU.
- Captures decoded instruction fields through a valid/ready handshake.
- Builds port_A, port_B and aluop for the ALU: immediate extension, shamt/LUI selection, EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts one bubble per load-use pair.

---
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register and ALU operand-select stage. Captures
//             decoded fields over a valid/ready handshake, pre-builds the
//             B-side immediate, forwards EX/MEM and MEM/WB results into the
//             ALU operands, and inserts one bubble per load-use pair.
//  Options  : IDEX_PERF_EN adds stall_cnt / bubble_cnt performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          dec_valid,
    output logic          dec_ready,
    input  logic [3:0]    dec_aluop,
    input  logic [DW-1:0] dec_rdat1,
    input  logic [DW-1:0] dec_rdat2,
    input  logic [RW-1:0] dec_rs,
    input  logic [RW-1:0] dec_rt,
    input  logic [RW-1:0] dec_wsel,
    input  logic          dec_wen,
    input  logic          dec_memread,
    input  logic [15:0]   dec_imm,
    input  logic [4:0]    dec_shamt,
    input  logic          dec_extop,
    input  logic          dec_asel,
    input  logic [1:0]    dec_bsel,
    input  logic          flush,
    input  logic          ex_ready,
    output logic          ex_valid,
    output logic [DW-1:0] port_A,
    output logic [DW-1:0] port_B,
    output logic [3:0]    aluop,
    output logic [RW-1:0] ex_wsel,
    output logic          ex_wen,
    output logic          ex_memread,
    input  logic          mem_wen,
    input  logic [RW-1:0] mem_wsel,
    input  logic [DW-1:0] mem_wdat,
    input  logic          wb_wen,
    input  logic [RW-1:0] wb_wsel,
    input  logic [DW-1:0] wb_wdat
`ifdef IDEX_PERF_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   bubble_cnt
`endif
);

    // Held entry
    logic          ex_valid_q;
    logic [3:0]    aluop_q;
    logic [DW-1:0] rdat1_q, rdat2_q;
    logic [RW-1:0] rs_q, rt_q, wsel_q;
    logic          wen_q, memread_q, asel_q, b_is_rt_q;
    logic [DW-1:0] immb_q, immb_d;
    // Last operands presented while valid, replayed while the stage is empty
    logic [DW-1:0] last_a_q, last_b_q;

    logic          uses_rt, hazard, capture;
    logic [DW-1:0] fwd_rs, fwd_rt, op_a, op_b;

    // Load-use detection against the instruction currently in decode
    assign uses_rt   = (dec_bsel == 2'd0) | dec_asel;
    assign hazard    = ex_valid_q & memread_q & (wsel_q != '0) &
                       ((wsel_q == dec_rs) | (uses_rt & (wsel_q == dec_rt)));
    assign dec_ready = ~RST & ~flush & ~hazard & (~ex_valid_q | ex_ready);
    assign capture   = dec_valid & dec_ready;

    // B-side immediate built from the decode fields at capture time
    always_comb begin
        immb_d = '0;
        case (dec_bsel)
            2'd1:    immb_d = dec_extop ? {{(DW-16){dec_imm[15]}}, dec_imm}
                                        : {{(DW-16){1'b0}}, dec_imm};
            2'd2:    immb_d = {{(DW-5){1'b0}}, dec_shamt};
            2'd3:    immb_d = {dec_imm, {(DW-16){1'b0}}};
            default: immb_d = '0;
        endcase
    end

    // Per-source forwarding: EX/MEM beats MEM/WB beats held data; r0 never forwards
    always_comb begin
        fwd_rs = rdat1_q;
        if ((rs_q != '0) && mem_wen && (mem_wsel == rs_q))
            fwd_rs = mem_wdat;
        else if ((rs_q != '0) && wb_wen && (wb_wsel == rs_q))
            fwd_rs = wb_wdat;
        fwd_rt = rdat2_q;
        if ((rt_q != '0) && mem_wen && (mem_wsel == rt_q))
            fwd_rt = mem_wdat;
        else if ((rt_q != '0) && wb_wen && (wb_wsel == rt_q))
            fwd_rt = wb_wdat;
    end

    assign op_a       = asel_q ? fwd_rt : fwd_rs;
    assign op_b       = b_is_rt_q ? fwd_rt : immb_q;
    assign port_A     = ex_valid_q ? op_a : last_a_q;
    assign port_B     = ex_valid_q ? op_b : last_b_q;
    assign aluop      = aluop_q;
    assign ex_valid   = ex_valid_q;
    assign ex_wsel    = wsel_q;
    assign ex_wen     = ex_valid_q & wen_q;
    assign ex_memread = ex_valid_q & memread_q;

    // Pipeline register: reset, flush, capture, drain, or hold with WB refresh
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_valid_q <= 1'b0;
            aluop_q    <= '0;
            rdat1_q    <= '0;
            rdat2_q    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wsel_q     <= '0;
            wen_q      <= 1'b0;
            memread_q  <= 1'b0;
            asel_q     <= 1'b0;
            b_is_rt_q  <= 1'b0;
            immb_q     <= '0;
            last_a_q   <= '0;
            last_b_q   <= '0;
        end else begin
            if (flush) begin
                ex_valid_q <= 1'b0;
            end else if (capture) begin
                ex_valid_q <= 1'b1;
                aluop_q    <= dec_aluop;
                rdat1_q    <= dec_rdat1;
                rdat2_q    <= dec_rdat2;
                rs_q       <= dec_rs;
                rt_q       <= dec_rt;
                wsel_q     <= dec_wsel;
                wen_q      <= dec_wen;
                memread_q  <= dec_memread;
                asel_q     <= dec_asel;
                b_is_rt_q  <= (dec_bsel == 2'd0);
                immb_q     <= immb_d;
            end else if (ex_valid_q & ex_ready) begin
                ex_valid_q <= 1'b0;
            end else if (ex_valid_q) begin
                // Results retiring while stalled must not be lost
                if (wb_wen && (wb_wsel != '0) && (wb_wsel == rs_q))
                    rdat1_q <= wb_wdat;
                if (wb_wen && (wb_wsel != '0) && (wb_wsel == rt_q))
                    rdat2_q <= wb_wdat;
            end
            if (ex_valid_q) begin
                last_a_q <= op_a;
                last_b_q <= op_b;
            end
        end
    end

`ifdef IDEX_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    // Stall and load-use bubble counters, wrapping at 2^32
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (dec_valid & ~dec_ready & ~flush)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (ex_valid_q & ex_ready & ~capture & hazard & ~flush)
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Self-checking bench for id_ex_stage: directed scenarios plus a
//             randomized run against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    localparam logic [3:0] ALU_ADD = 4'h3;
    localparam logic [3:0] ALU_SLL = 4'h7;

    logic        CLK, RST;
    logic        dec_valid, dec_ready;
    logic [3:0]  dec_aluop;
    logic [31:0] dec_rdat1, dec_rdat2;
    logic [4:0]  dec_rs, dec_rt, dec_wsel;
    logic        dec_wen, dec_memread;
    logic [15:0] dec_imm;
    logic [4:0]  dec_shamt;
    logic        dec_extop, dec_asel;
    logic [1:0]  dec_bsel;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] port_A, port_B;
    logic [3:0]  aluop;
    logic [4:0]  ex_wsel;
    logic        ex_wen, ex_memread;
    logic        mem_wen;
    logic [4:0]  mem_wsel;
    logic [31:0] mem_wdat;
    logic        wb_wen;
    logic [4:0]  wb_wsel;
    logic [31:0] wb_wdat;
`ifdef IDEX_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.DW(32), .RW(5)) dut (
        .CLK(CLK), .RST(RST),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_aluop(dec_aluop),
        .dec_rdat1(dec_rdat1), .dec_rdat2(dec_rdat2),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wsel(dec_wsel),
        .dec_wen(dec_wen), .dec_memread(dec_memread), .dec_imm(dec_imm),
        .dec_shamt(dec_shamt), .dec_extop(dec_extop), .dec_asel(dec_asel),
        .dec_bsel(dec_bsel), .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .port_A(port_A), .port_B(port_B), .aluop(aluop),
        .ex_wsel(ex_wsel), .ex_wen(ex_wen), .ex_memread(ex_memread),
        .mem_wen(mem_wen), .mem_wsel(mem_wsel), .mem_wdat(mem_wdat),
        .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat)
`ifdef IDEX_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one edge and land 2 time units past it
    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_aluop = 0; dec_rdat1 = 0; dec_rdat2 = 0;
        dec_rs = 0; dec_rt = 0; dec_wsel = 0; dec_wen = 0; dec_memread = 0;
        dec_imm = 0; dec_shamt = 0; dec_extop = 0; dec_asel = 0; dec_bsel = 0;
        flush = 0; mem_wen = 0; mem_wsel = 0; mem_wdat = 0;
        wb_wen = 0; wb_wsel = 0; wb_wdat = 0;
    endtask

    // Present the decode fields for one edge, then drop dec_valid
    task automatic send();
        dec_valid = 1;
        cyc();
        dec_valid = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        ex_ready = 1; RST = 1; dec_valid = 1; dec_rdat1 = 32'h1234; dec_rdat2 = 32'h5678;
        for (int i = 0; i < 2; i++) begin
            cyc();
            total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL rst_dec_ready got=%b exp=0", dec_ready); end
            total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
            total++; if (port_A !== 32'h0) begin bad++; $display("FAIL rst_port_A got=%h exp=0", port_A); end
            total++; if (port_B !== 32'h0) begin bad++; $display("FAIL rst_port_B got=%h exp=0", port_B); end
        end
        dec_valid = 0; RST = 0;
        #1;
        total++; if (ex_valid !== 1'b0 || port_A !== 32'h0 || port_B !== 32'h0 || aluop !== 4'h0 || ex_wen !== 1'b0)
            begin bad++; $display("FAIL rst_release got v=%b A=%h B=%h op=%h exp all zero", ex_valid, port_A, port_B, aluop); end
    endtask

    task automatic test_add_capture();
        clear_inputs();
        ex_ready = 1; dec_aluop = ALU_ADD; dec_rdat1 = 5; dec_rdat2 = 7;
        dec_rs = 1; dec_rt = 2; dec_wsel = 3; dec_wen = 1; dec_bsel = 0;
        dec_valid = 1; #1;
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL add_dec_ready got=%b exp=1", dec_ready); end
        send();
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL add_ex_valid got=%b exp=1", ex_valid); end
        total++; if (port_A !== 32'd5) begin bad++; $display("FAIL add_port_A got=%h exp=5", port_A); end
        total++; if (port_B !== 32'd7) begin bad++; $display("FAIL add_port_B got=%h exp=7", port_B); end
        total++; if (aluop !== ALU_ADD) begin bad++; $display("FAIL add_aluop got=%h exp=%h", aluop, ALU_ADD); end
        total++; if (ex_wen !== 1'b1 || ex_wsel !== 5'd3) begin bad++; $display("FAIL add_wen_wsel got=%b/%0d exp=1/3", ex_wen, ex_wsel); end
        cyc();
        total++; if (ex_valid !== 1'b0 || ex_wen !== 1'b0) begin bad++; $display("FAIL add_drain got v=%b wen=%b exp=0/0", ex_valid, ex_wen); end
        total++; if (port_A !== 32'd5 || port_B !== 32'd7) begin bad++; $display("FAIL add_hold_ports got=%h/%h exp=5/7", port_A, port_B); end
    endtask

    task automatic test_immediates();
        clear_inputs();
        ex_ready = 1; dec_aluop = ALU_ADD; dec_bsel = 1; dec_extop = 1; dec_imm = 16'hFFFC;
        send();
        total++; if (port_B !== 32'hFFFFFFFC) begin bad++; $display("FAIL imm_sext got=%h exp=FFFFFFFC", port_B); end
        dec_extop = 0;
        send();
        total++; if (port_B !== 32'h0000FFFC) begin bad++; $display("FAIL imm_zext got=%h exp=0000FFFC", port_B); end
        dec_bsel = 3; dec_imm = 16'h1234;
        send();
        total++; if (port_B !== 32'h12340000) begin bad++; $display("FAIL imm_lui got=%h exp=12340000", port_B); end
        dec_aluop = ALU_SLL; dec_asel = 1; dec_bsel = 2; dec_shamt = 4; dec_rt = 2; dec_rdat2 = 32'h80; dec_imm = 16'hABCD;
        send();
        total++; if (port_B !== 32'd4) begin bad++; $display("FAIL imm_shamt got=%h exp=4", port_B); end
        total++; if (port_A !== 32'h80) begin bad++; $display("FAIL sll_port_A got=%h exp=80", port_A); end
        cyc();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        ex_ready = 0; dec_rs = 8; dec_rdat1 = 32'h11; dec_rt = 0; dec_rdat2 = 32'h22; dec_bsel = 0;
        send();
        mem_wen = 1; mem_wsel = 8; mem_wdat = 32'hAA;
        wb_wen = 1; wb_wsel = 8; wb_wdat = 32'hBB;
        #1;
        total++; if (port_A !== 32'hAA) begin bad++; $display("FAIL fwd_mem got=%h exp=AA", port_A); end
        total++; if (port_B !== 32'h22) begin bad++; $display("FAIL fwd_r0_rt got=%h exp=22", port_B); end
        mem_wen = 0; #1;
        total++; if (port_A !== 32'hBB) begin bad++; $display("FAIL fwd_wb got=%h exp=BB", port_A); end
        wb_wen = 0; ex_ready = 1;
        cyc();
        ex_ready = 0; dec_rs = 0; dec_rdat1 = 32'h33;
        send();
        mem_wen = 1; mem_wsel = 0; mem_wdat = 32'hAA;
        wb_wen = 1; wb_wsel = 0; wb_wdat = 32'hBB;
        #1;
        total++; if (port_A !== 32'h33) begin bad++; $display("FAIL fwd_r0 got=%h exp=33", port_A); end
        mem_wen = 0; wb_wen = 0; ex_ready = 1;
        cyc();
    endtask

    task automatic test_load_use();
        logic [31:0] b0;
        clear_inputs();
        b0 = 0;
        ex_ready = 1; dec_memread = 1; dec_wen = 1; dec_wsel = 9; dec_rs = 1; dec_rt = 2; dec_bsel = 1;
        send();
`ifdef IDEX_PERF_EN
        b0 = bubble_cnt;
`endif
        total++; if (ex_memread !== 1'b1) begin bad++; $display("FAIL lu_memread got=%b exp=1", ex_memread); end
        clear_inputs();
        dec_rs = 9; dec_rt = 2; dec_bsel = 1; dec_rdat1 = 32'h99; dec_aluop = ALU_ADD;
        dec_valid = 1; #1;
        total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL lu_ready_blocked got=%b exp=0", dec_ready); end
        cyc();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
        total++; if (dec_ready !== 1'b1) begin bad++; $display("FAIL lu_ready_after got=%b exp=1", dec_ready); end
        cyc();
        dec_valid = 0; #1;
        total++; if (ex_valid !== 1'b1 || port_A !== 32'h99) begin bad++; $display("FAIL lu_capture got v=%b A=%h exp=1/99", ex_valid, port_A); end
`ifdef IDEX_PERF_EN
        total++; if (bubble_cnt - b0 !== 32'd1) begin bad++; $display("FAIL lu_bubble_cnt got=%0d exp=1", bubble_cnt - b0); end
`else
        total += 0; b0 = b0 + 0;
`endif
        cyc();
    endtask

    task automatic test_stall_flush();
        logic [31:0] s0;
        clear_inputs();
        s0 = 0;
        ex_ready = 0; dec_rs = 1; dec_rdat1 = 32'h1; dec_rt = 3; dec_rdat2 = 32'h10; dec_bsel = 0;
        send();
`ifdef IDEX_PERF_EN
        s0 = stall_cnt;
`endif
        dec_valid = 1; #1;
        total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL st_ready got=%b exp=0", dec_ready); end
        total++; if (port_B !== 32'h10) begin bad++; $display("FAIL st_port_B0 got=%h exp=10", port_B); end
        cyc();
        wb_wen = 1; wb_wsel = 3; wb_wdat = 32'h55; #1;
        total++; if (port_B !== 32'h55) begin bad++; $display("FAIL st_fwd_wb got=%h exp=55", port_B); end
        cyc();
        wb_wen = 0; #1;
        total++; if (port_B !== 32'h55 || ex_valid !== 1'b1) begin bad++; $display("FAIL st_refresh got B=%h v=%b exp=55/1", port_B, ex_valid); end
        flush = 1; #1;
        total++; if (dec_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", dec_ready); end
        cyc();
        flush = 0; dec_valid = 0; #1;
        total++; if (ex_valid !== 1'b0 || port_B !== 32'h55) begin bad++; $display("FAIL fl_squash got v=%b B=%h exp=0/55", ex_valid, port_B); end
`ifdef IDEX_PERF_EN
        total++; if (stall_cnt - s0 !== 32'd2) begin bad++; $display("FAIL st_stall_cnt got=%0d exp=2", stall_cnt - s0); end
`else
        s0 = s0 + 0;
`endif
        ex_ready = 1;
    endtask

    // Reference model: what the stage holds, described as a transaction
    typedef struct {
        bit        valid;
        bit [3:0]  op;
        bit [31:0] a_data, b_data, imm;
        bit [4:0]  rs, rt, wsel;
        bit        wen, load, a_from_rt, b_from_rt;
    } entry_t;

    function automatic bit [31:0] m_fwd(bit [4:0] r, bit [31:0] held);
        if (r == 0) return held;
        if (mem_wen && mem_wsel == r) return mem_wdat;
        if (wb_wen && wb_wsel == r) return wb_wdat;
        return held;
    endfunction

    function automatic bit [31:0] m_imm(bit [1:0] sel, bit [15:0] imm, bit ext, bit [4:0] sh);
        bit [31:0] v;
        v = 32'(imm);
        case (sel)
            2'd1: return (ext && imm >= 16'd32768) ? v + 32'hFFFF0000 : v;
            2'd2: return 32'(sh);
            2'd3: return v * 32'd65536;
            default: return 0;
        endcase
    endfunction

    task automatic test_random();
        entry_t    e;
        bit [31:0] last_a, last_b, exp_a, exp_b, n_stall, n_bubble;
        bit        needs_rt, blocked, exp_rdy;
        clear_inputs();
        ex_ready = 1; RST = 1;
        cyc();
        RST = 0;
        e = '{default: 0};
        last_a = 0; last_b = 0; n_stall = 0; n_bubble = 0;
        for (int i = 0; i < 600; i++) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_aluop   = 4'($urandom_range(0, 15));
            dec_rdat1   = $urandom; dec_rdat2 = $urandom;
            dec_rs      = 5'($urandom_range(0, 3));
            dec_rt      = 5'($urandom_range(0, 3));
            dec_wsel    = 5'($urandom_range(0, 3));
            dec_wen     = 1'($urandom_range(0, 1));
            dec_memread = ($urandom_range(0, 2) == 0);
            dec_imm     = 16'($urandom_range(0, 65535));
            dec_shamt   = 5'($urandom_range(0, 31));
            dec_extop   = 1'($urandom_range(0, 1));
            dec_asel    = ($urandom_range(0, 3) == 0);
            dec_bsel    = 2'($urandom_range(0, 3));
            ex_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            mem_wen     = 1'($urandom_range(0, 1));
            mem_wsel    = 5'($urandom_range(0, 3));
            mem_wdat    = $urandom;
            wb_wen      = 1'($urandom_range(0, 1));
            wb_wsel     = 5'($urandom_range(0, 3));
            wb_wdat     = $urandom;
            #1;
            needs_rt = dec_asel || dec_bsel == 0;
            blocked  = e.valid && e.load && e.wsel != 0 &&
                       (e.wsel == dec_rs || (needs_rt && e.wsel == dec_rt));
            exp_rdy  = !flush && !blocked && (!e.valid || ex_ready);
            exp_a    = e.a_from_rt ? m_fwd(e.rt, e.b_data) : m_fwd(e.rs, e.a_data);
            exp_b    = e.b_from_rt ? m_fwd(e.rt, e.b_data) : e.imm;
            if (!e.valid) begin exp_a = last_a; exp_b = last_b; end
            total++; if (dec_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, dec_ready, exp_rdy); end
            total++; if (ex_valid !== e.valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, ex_valid, e.valid); end
            total++; if (port_A !== exp_a) begin bad++; $display("FAIL rnd_port_A cyc=%0d got=%h exp=%h", i, port_A, exp_a); end
            total++; if (port_B !== exp_b) begin bad++; $display("FAIL rnd_port_B cyc=%0d got=%h exp=%h", i, port_B, exp_b); end
            total++; if (aluop !== e.op || ex_wsel !== e.wsel) begin bad++; $display("FAIL rnd_op_wsel cyc=%0d got=%h/%0d exp=%h/%0d", i, aluop, ex_wsel, e.op, e.wsel); end
            total++; if (ex_wen !== (e.valid && e.wen) || ex_memread !== (e.valid && e.load))
                begin bad++; $display("FAIL rnd_flags cyc=%0d got=%b%b exp=%b%b", i, ex_wen, ex_memread, e.valid && e.wen, e.valid && e.load); end
`ifdef IDEX_PERF_EN
            total++; if (stall_cnt !== n_stall || bubble_cnt !== n_bubble)
                begin bad++; $display("FAIL rnd_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i, stall_cnt, bubble_cnt, n_stall, n_bubble); end
`endif
            // Advance the model by one clock
            if (e.valid) begin last_a = exp_a; last_b = exp_b; end
            if (dec_valid && !exp_rdy && !flush) n_stall++;
            if (flush) e.valid = 0;
            else if (dec_valid && exp_rdy) begin
                e.valid = 1; e.op = dec_aluop; e.a_data = dec_rdat1; e.b_data = dec_rdat2;
                e.rs = dec_rs; e.rt = dec_rt; e.wsel = dec_wsel; e.wen = dec_wen;
                e.load = dec_memread; e.a_from_rt = dec_asel; e.b_from_rt = (dec_bsel == 0);
                e.imm = m_imm(dec_bsel, dec_imm, dec_extop, dec_shamt);
            end else if (e.valid && ex_ready) begin
                e.valid = 0;
                if (blocked) n_bubble++;
            end else if (e.valid && wb_wen && wb_wsel != 0) begin
                if (wb_wsel == e.rs) e.a_data = wb_wdat;
                if (wb_wsel == e.rt) e.b_data = wb_wdat;
            end
            cyc();
        end
    endtask

    initial begin
        RST = 1; ex_ready = 1;
        clear_inputs();
        test_reset();
        test_add_capture();
        test_immediates();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
